motor_cmd_dispatch: RTL and testbench

MOTOR_CMD_DISPATCH -- requirements
Module: motor_cmd_dispatch

---
 rtl/vert_pkg.sv | 31 +++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/motor_cmd_dispatch.sv | 183 ++++++++++++++++++
 tb/tb_motor_cmd_dispatch.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vert_pkg.sv
// Shared frame layout, status pack constants and TX state type for the
// motor command dispatcher.
package vert_pkg;

  localparam int unsigned FRAME_LEN = 5;
  localparam int unsigned FRAME_W   = 8 * FRAME_LEN;

  localparam int unsigned CH_LSB    = 0;
  localparam int unsigned CH_W      = 4;
  localparam int unsigned DIV_LSB   = 4;
  localparam int unsigned DIV_W     = 15;
  localparam int unsigned STEPS_LSB = 19;
  localparam int unsigned STEPS_W   = 15;
  localparam int unsigned DIR_BIT   = 34;

  localparam int unsigned CMD_W     = DIV_W + STEPS_W + 1;

  localparam int unsigned TAG_W     = 3;
  localparam int unsigned GROUP_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } txState_t;

  function automatic int unsigned groupCount(input int unsigned nch);
    return (nch + GROUP_W - 1) / GROUP_W;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Per-channel command queue: registered occupancy, no fall-through, flushable.
module cmd_fifo #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK_SE_AR,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             flush,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] headData
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      occ;
  logic             pushOk;
  logic             popOk;

  assign valid    = (occ != '0);
  assign full     = (occ == FULL_OCC);
  // Admission looks only at the current occupancy, so a same-cycle pop never frees room.
  assign pushOk   = push & ~full;
  assign popOk    = pop & valid;
  assign headData = valid ? mem[rdPtr] : '0;

  always_ff @(posedge CLK_SE_AR) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (popOk)  rdPtr <= rdPtr + AW'(1);
      unique case ({pushOk, popOk})
        2'b10:   occ <= occ + (AW + 1)'(1);
        2'b01:   occ <= occ - (AW + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK_SE_AR) begin
    if (rst_n && !flush && pushOk) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/motor_cmd_dispatch.sv
// UART frame parser feeding per-channel motor command queues, plus a
// free-running status transmitter reporting pending and limit-switch bits.
module motor_cmd_dispatch
  import vert_pkg::*;
#(
  parameter int unsigned NCH       = 10,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TO_CYCLES = 2400000,
  parameter int unsigned BYTE_GAP  = 4095,
  parameter int unsigned PACK_GAP  = 262143
) (
  input  logic                 CLK_SE_AR,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [NCH-1:0]       cmd_valid,
  input  logic [NCH-1:0]       cmd_ready,
  output logic [DIV_W*NCH-1:0] cmd_div,
  output logic [DIV_W*NCH-1:0] cmd_steps,
  output logic [NCH-1:0]       cmd_dir,
  input  logic [NCH-1:0]       term,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic [NCH-1:0]       ovf_flag,
  output logic                 frame_err
);

  localparam int unsigned G     = groupCount(NCH);
  localparam int unsigned PAD_W = GROUP_W * G;
  localparam logic [TAG_W-1:0] LAST_K = TAG_W'(2 * G - 1);
  localparam logic [31:0] TO_LOAD   = 32'(TO_CYCLES);
  localparam logic [31:0] BYTE_LOAD = 32'(BYTE_GAP - 1);
  localparam logic [31:0] PACK_LOAD = 32'(PACK_GAP - 1);

  // ---------------- frame parser ----------------
  logic [FRAME_W-1:0] frame;
  logic [2:0]         byteCnt;
  logic [31:0]        toCnt;
  logic               commit;
  logic               chOk;
  logic               isFlush;
  logic [4:0]         chIdx;
  logic [CMD_W-1:0]   cmdWord;

  assign commit  = (byteCnt == 3'(FRAME_LEN));
  assign chIdx   = {1'b0, frame[CH_LSB +: CH_W]};
  assign chOk    = (chIdx < 5'(NCH));
  assign isFlush = (frame[STEPS_LSB +: STEPS_W] == '0);
  assign cmdWord = {frame[DIR_BIT], frame[STEPS_LSB +: STEPS_W], frame[DIV_LSB +: DIV_W]};

  always_ff @(posedge CLK_SE_AR) begin
    if (!rst_n) begin
      frame     <= '0;
      byteCnt   <= '0;
      toCnt     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid) begin
        // A byte arriving on the commit cycle starts the next frame.
        frame   <= {rx_data, frame[FRAME_W-1:8]};
        toCnt   <= TO_LOAD;
        byteCnt <= commit ? 3'd1 : byteCnt + 3'd1;
      end else begin
        if (toCnt != '0) toCnt <= toCnt - 32'd1;
        if (commit) begin
          byteCnt <= '0;
        end else if (toCnt == 32'd1 && byteCnt != '0) begin
          byteCnt   <= '0;
          frame_err <= 1'b1;
        end
      end
      if (commit && !chOk) frame_err <= 1'b1;
    end
  end

  // ---------------- per-channel queues ----------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic             chHit;
    logic             pushC;
    logic             flushC;
    logic             fullC;
    logic             ovfReg;
    logic [CMD_W-1:0] head;

    assign chHit  = commit && chOk && (chIdx == 5'(c));
    assign pushC  = chHit && !isFlush;
    assign flushC = chHit && isFlush;

    cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK_SE_AR (CLK_SE_AR),
      .rst_n     (rst_n),
      .push      (pushC),
      .pushData  (cmdWord),
      .pop       (cmd_valid[c] & cmd_ready[c]),
      .flush     (flushC),
      .valid     (cmd_valid[c]),
      .full      (fullC),
      .headData  (head)
    );

    always_ff @(posedge CLK_SE_AR) begin
      if (!rst_n)              ovfReg <= 1'b0;
      else if (flushC)         ovfReg <= 1'b0;
      else if (pushC && fullC) ovfReg <= 1'b1;
    end

    assign ovf_flag[c]                  = ovfReg;
    assign cmd_div[DIV_W*c +: DIV_W]    = head[DIV_W-1:0];
    assign cmd_steps[DIV_W*c +: DIV_W]  = head[DIV_W +: STEPS_W];
    assign cmd_dir[c]                   = head[CMD_W-1];
  end

  // ---------------- status transmitter ----------------
  txState_t           state;
  txState_t           nextState;
  logic [TAG_W-1:0]   k;
  logic [TAG_W-1:0]   kNext;
  logic [31:0]        gapCnt;
  logic [31:0]        gapNext;
  logic [PAD_W-1:0]   pPad;
  logic [PAD_W-1:0]   tPad;
  logic [GROUP_W-1:0] dataBits;

  always_comb begin
    pPad            = '0;
    tPad            = '0;
    pPad[NCH-1:0]   = cmd_valid;
    tPad[NCH-1:0]   = ~term;
    dataBits        = '0;
    for (int unsigned g = 0; g < G; g++) begin
      if (k == TAG_W'(g))     dataBits = pPad[GROUP_W*g +: GROUP_W];
      if (k == TAG_W'(g + G)) dataBits = tPad[GROUP_W*g +: GROUP_W];
    end
  end

  always_comb begin
    nextState = state;
    kNext     = k;
    gapNext   = gapCnt;
    unique case (state)
      IDLE: begin
        nextState = SEND;
        kNext     = '0;
      end
      SEND: begin
        nextState = GAP;
        if (k == LAST_K) begin
          gapNext = PACK_LOAD;
          kNext   = '0;
        end else begin
          gapNext = BYTE_LOAD;
          kNext   = k + TAG_W'(1);
        end
      end
      GAP: begin
        if (gapCnt == '0) nextState = SEND;
        else              gapNext   = gapCnt - 32'd1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK_SE_AR) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      gapCnt   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= nextState;
      k        <= kNext;
      gapCnt   <= gapNext;
      tx_start <= (state == SEND);
      if (state == SEND) tx_data <= {k, dataBits};
    end
  end

endmodule

// File: tb/tb_motor_cmd_dispatch.sv
// Directed and randomized checks of motor_cmd_dispatch against a queue-level model.
module tb_motor_cmd_dispatch;

  localparam int NCH = 10;
  localparam int DEPTH = 4;
  localparam int TO = 40;
  localparam int BG = 6;
  localparam int PG = 20;
  localparam int G = (NCH + 4) / 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [NCH-1:0]     cmd_valid;
  logic [NCH-1:0]     cmd_ready;
  logic [15*NCH-1:0]  cmd_div;
  logic [15*NCH-1:0]  cmd_steps;
  logic [NCH-1:0]     cmd_dir;
  logic [NCH-1:0]     term;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic [NCH-1:0]     ovf_flag;
  logic               frame_err;

  int nAssert = 0;
  int nFail = 0;

  // model: per-channel queues of commands and sticky overflow bits
  logic [14:0] mdiv   [NCH][DEPTH];
  logic [14:0] msteps [NCH][DEPTH];
  logic        mdir   [NCH][DEPTH];
  int          mcnt   [NCH];
  logic [NCH-1:0] movf;

  always #5 clk = ~clk;

  motor_cmd_dispatch #(
    .NCH       (NCH),
    .DEPTH     (DEPTH),
    .TO_CYCLES (TO),
    .BYTE_GAP  (BG),
    .PACK_GAP  (PG)
  ) dut (
    .CLK_SE_AR (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_div   (cmd_div),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .term      (term),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .ovf_flag  (ovf_flag),
    .frame_err (frame_err)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    movf = '0;
  endtask

  function automatic logic [NCH-1:0] expValid();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (mcnt[c] != 0);
    return v;
  endfunction

  function automatic logic [15*NCH-1:0] expDiv();
    logic [15*NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) if (mcnt[c] != 0) v[15*c +: 15] = mdiv[c][0];
    return v;
  endfunction

  function automatic logic [15*NCH-1:0] expSteps();
    logic [15*NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) if (mcnt[c] != 0) v[15*c +: 15] = msteps[c][0];
    return v;
  endfunction

  function automatic logic [NCH-1:0] expDir();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) if (mcnt[c] != 0) v[c] = mdir[c][0];
    return v;
  endfunction

  function automatic logic [7:0] expByte(input int kk);
    logic [4:0] bits = '0;
    logic [2:0] tag = 3'(kk);
    int grp = (kk < G) ? kk : kk - G;
    for (int i = 0; i < 5; i++) begin
      int chn = grp * 5 + i;
      if (chn < NCH) bits[i] = (kk < G) ? (mcnt[chn] != 0) : ~term[chn];
    end
    return {tag, bits};
  endfunction

  // apply one received 40-bit frame to the model; err reports a bad channel
  task automatic modelApply(input logic [39:0] f, output logic err);
    int ch = int'(f & 40'hF);
    logic [14:0] dv = 15'((f >> 4) & 40'h7FFF);
    logic [14:0] st = 15'((f >> 19) & 40'h7FFF);
    logic dr = f[34];
    err = 1'b0;
    if (ch >= NCH) err = 1'b1;
    else if (st == 0) begin
      mcnt[ch] = 0;
      movf[ch] = 1'b0;
    end else if (mcnt[ch] < DEPTH) begin
      mdiv[ch][mcnt[ch]] = dv;
      msteps[ch][mcnt[ch]] = st;
      mdir[ch][mcnt[ch]] = dr;
      mcnt[ch]++;
    end else movf[ch] = 1'b1;
  endtask

  task automatic modelPop(input logic [NCH-1:0] r);
    for (int c = 0; c < NCH; c++) begin
      if (r[c] && mcnt[c] > 0) begin
        for (int j = 0; j < DEPTH - 1; j++) begin
          mdiv[c][j] = mdiv[c][j+1];
          msteps[c][j] = msteps[c][j+1];
          mdir[c][j] = mdir[c][j+1];
        end
        mcnt[c]--;
      end
    end
  endtask

  task automatic checkAll(input string tag, input logic expErr);
    check({tag, ".valid"}, cmd_valid, expValid());
    check({tag, ".div"},   cmd_div,   expDiv());
    check({tag, ".steps"}, cmd_steps, expSteps());
    check({tag, ".dir"},   cmd_dir,   expDir());
    check({tag, ".ovf"},   ovf_flag,  movf);
    check({tag, ".ferr"},  frame_err, expErr);
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) begin
      sendByte(f[8*i +: 8]);
      if (i < 4) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic doFrame(input string tag, input logic [39:0] f);
    logic err;
    sendFrame(f);
    check({tag, ".nofall"}, cmd_valid, expValid());
    step();
    modelApply(f, err);
    checkAll(tag, err);
  endtask

  function automatic logic [39:0] mkFrame(input int ch, input int dv, input int st, input logic dr);
    logic [39:0] f;
    f = 40'(($urandom & 32'h1F)) << 35;
    f = f | (40'(dr) << 34) | (40'(st & 32'h7FFF) << 19) | (40'(dv & 32'h7FFF) << 4) | 40'(ch & 15);
    return f;
  endfunction

  task automatic popCycle(input string tag, input logic [NCH-1:0] r);
    cmd_ready = r;
    step();
    cmd_ready = '0;
    modelPop(r);
    checkAll(tag, 1'b0);
  endtask

  task automatic waitPulse(output int gap, output logic ok);
    gap = 0;
    ok = 1'b0;
    for (int i = 0; i < PG + 10; i++) begin
      step();
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      gap++;
    end
  endtask

  task automatic txPack(input string tag);
    int gap;
    logic ok;
    logic found = 1'b0;
    for (int t = 0; t < 2 * G + 2; t++) begin
      waitPulse(gap, ok);
      if (ok && tx_data[7:5] == 3'd0) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, ".sync"}, found, 1'b1);
    check({tag, ".b0"}, tx_data, expByte(0));
    for (int kk = 1; kk <= 2 * G; kk++) begin
      waitPulse(gap, ok);
      check({tag, ".pulse"}, ok, 1'b1);
      check({tag, ".gap"}, gap, (kk == 2 * G) ? PG : BG);
      check({tag, ".byte"}, tx_data, expByte(kk % (2 * G)));
    end
  endtask

  initial begin
    logic [39:0] f;
    logic err;
    int pulses;

    rst_n = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    cmd_ready = '0;
    term = '1;
    modelReset();
    repeat (3) step();
    checkAll("reset", 1'b0);
    check("reset.txs", tx_start, 1'b0);
    check("reset.txd", tx_data, 8'h00);
    rst_n = 1'b1;

    // reference frame 0x0578563412 to channel 2
    f = 40'h0578563412;
    doFrame("ref", f);

    // randomized frames and pops
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) popCycle("rpop", NCH'($urandom));
      else begin
        int st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 32767);
        doFrame("rfrm", mkFrame($urandom_range(0, 11), $urandom_range(0, 32767), st, 1'($urandom)));
      end
    end

    // overflow then flush on channel 1
    doFrame("fl1", mkFrame(1, 5, 0, 1'b0));
    for (int i = 0; i <= DEPTH; i++)
      doFrame("ovf", mkFrame(1, 100 + i, 200 + i, 1'(i)));
    // push to full queue in the same cycle as a pop is not admitted
    f = mkFrame(1, 7, 9, 1'b1);
    sendFrame(f);
    cmd_ready = NCH'(2);
    step();
    cmd_ready = '0;
    modelApply(f, err);
    modelPop(NCH'(2));
    checkAll("fullpop", err);
    doFrame("flush", mkFrame(1, 0, 0, 1'b0));

    // timeout after three bytes
    f = mkFrame(4, 321, 654, 1'b1);
    for (int i = 0; i < 3; i++) sendByte(f[8*i +: 8]);
    pulses = 0;
    repeat (TO + 5) begin
      step();
      if (frame_err) pulses++;
    end
    check("timeout.pulses", pulses, 1);
    doFrame("after_to", mkFrame(5, 11, 22, 1'b0));

    // byte arriving on the expiry cycle wins over the timeout
    f = mkFrame(6, 1234, 4321, 1'b0);
    for (int i = 0; i < 3; i++) sendByte(f[8*i +: 8]);
    pulses = 0;
    repeat (TO - 1) begin
      step();
      if (frame_err) pulses++;
    end
    sendByte(f[31:24]);
    if (frame_err) pulses++;
    sendByte(f[39:32]);
    if (frame_err) pulses++;
    check("edge_to.pulses", pulses, 0);
    step();
    modelApply(f, err);
    checkAll("edge_to", err);

    // out-of-range channel
    doFrame("badch", mkFrame(15, 1, 1, 1'b0));

    // status pack with only channel 3 pending
    for (int c = 0; c < NCH; c++) doFrame("clr", mkFrame(c, 0, 0, 1'b0));
    doFrame("ch3", mkFrame(3, 50, 60, 1'b0));
    term = 10'h3FE;
    txPack("tx0");
    term = NCH'($urandom);
    doFrame("ch7", mkFrame(7, 70, 80, 1'b1));
    txPack("tx1");
    term = NCH'($urandom);
    txPack("tx2");
    term = '1;

    // reset during byte 4 with a full queue
    for (int i = 0; i <= DEPTH; i++) doFrame("fill", mkFrame(1, i, i + 1, 1'b0));
    f = mkFrame(2, 9, 9, 1'b0);
    for (int i = 0; i < 4; i++) sendByte(f[8*i +: 8]);
    rx_data = f[39:32];
    rx_valid = 1'b1;
    rst_n = 1'b0;
    step();
    rx_valid = 1'b0;
    modelReset();
    checkAll("rst", 1'b0);
    check("rst.txs", tx_start, 1'b0);
    check("rst.txd", tx_data, 8'h00);
    rst_n = 1'b1;
    step();
    doFrame("post_rst", mkFrame(8, 333, 444, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
